// File: rtl/grant_tenure_ctrl.sv
// Grant tenure controller: forwards the FSM grant to the client, bounds its tenure,
// drains busy clients and pulses revoke-request/revoke-done. Optional stats: GRANT_TENURE_STATS_EN.
module grant_tenure_ctrl #(
    parameter int unsigned MAX_TENURE = 16,
    parameter int unsigned COOLDOWN   = 4,
    localparam int unsigned CNT_W     = $clog2(MAX_TENURE)
) (
    input  logic             i_ck,
    input  logic             i_arst,
    input  logic             i_grant,
    input  logic             i_clientReq,
    input  logic             i_clientBusy,
    output logic             o_clientGrant,
    output logic             o_revokeReq,
    output logic             o_revokeDone,
    output logic [CNT_W-1:0] o_tenureCount
`ifdef GRANT_TENURE_STATS_EN
    ,
    output logic [7:0]       o_timeoutCnt
`endif
);

    localparam int unsigned COOL_W = $clog2(COOLDOWN);
    localparam logic [CNT_W-1:0]  TEN_LAST  = CNT_W'(MAX_TENURE - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_COOLDOWN
    } state_t;

    state_t              r_state;
    state_t              w_stateNx;
    logic [CNT_W-1:0]    r_tenure;
    logic [CNT_W-1:0]    w_tenureNx;
    logic [COOL_W-1:0]   r_cool;
    logic [COOL_W-1:0]   w_coolNx;
    logic                w_trigger;

    always_ff @(posedge i_ck or posedge i_arst) begin
        if (i_arst) begin
            r_state  <= S_IDLE;
            r_tenure <= '0;
            r_cool   <= '0;
        end else begin
            r_state  <= w_stateNx;
            r_tenure <= w_tenureNx;
            r_cool   <= w_coolNx;
        end
    end

    assign w_trigger = !i_clientReq || (r_tenure == TEN_LAST);

    // Loss of i_grant in ACTIVE/DRAIN is an abort and outranks the trigger.
    always_comb begin
        w_stateNx  = r_state;
        w_tenureNx = r_tenure;
        w_coolNx   = r_cool;
        case (r_state)
            S_IDLE: begin
                if (i_grant) begin
                    w_stateNx  = S_ACTIVE;
                    w_tenureNx = '0;
                end
            end
            S_ACTIVE: begin
                if (!i_grant) begin
                    w_stateNx = S_IDLE;
                end else if (w_trigger) begin
                    if (i_clientBusy) begin
                        w_stateNx = S_DRAIN;
                    end else begin
                        w_stateNx = S_COOLDOWN;
                        w_coolNx  = COOL_LOAD;
                    end
                end else begin
                    w_tenureNx = r_tenure + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (!i_grant) begin
                    w_stateNx = S_IDLE;
                end else if (!i_clientBusy) begin
                    w_stateNx = S_COOLDOWN;
                    w_coolNx  = COOL_LOAD;
                end
            end
            S_COOLDOWN: begin
                if (r_cool == '0) begin
                    w_stateNx = S_IDLE;
                end else begin
                    w_coolNx = r_cool - COOL_W'(1);
                end
            end
            default: w_stateNx = S_IDLE;
        endcase
    end

    assign o_clientGrant = (r_state == S_ACTIVE) || (r_state == S_DRAIN);
    assign o_revokeReq   = (r_state == S_COOLDOWN) && (r_cool == COOL_LOAD);
    assign o_revokeDone  = (r_state == S_COOLDOWN) && (r_cool == '0);
    assign o_tenureCount = r_tenure;

`ifdef GRANT_TENURE_STATS_EN
    logic [7:0] r_timeoutCnt;
    logic       w_tmoInc;

    // A trigger with the client still requesting can only be the tenure limit.
    assign w_tmoInc = (r_state == S_ACTIVE) && i_grant && i_clientReq && (r_tenure == TEN_LAST);

    always_ff @(posedge i_ck or posedge i_arst) begin
        if (i_arst) begin
            r_timeoutCnt <= '0;
        end else if (w_tmoInc && (r_timeoutCnt != 8'hFF)) begin
            r_timeoutCnt <= r_timeoutCnt + 8'd1;
        end
    end

    assign o_timeoutCnt = r_timeoutCnt;
`endif

endmodule

// File: tb/tb_grant_tenure_ctrl.sv
// Randomized and directed bench for grant_tenure_ctrl against an episode-level reference model.
module tb_grant_tenure_ctrl;

    localparam int unsigned MAXT  = 16;
    localparam int unsigned COOL  = 4;
    localparam int unsigned CNT_W = 4;

    logic             i_ck = 1'b0;
    logic             i_arst = 1'b1;
    logic             i_grant = 1'b0;
    logic             i_clientReq = 1'b0;
    logic             i_clientBusy = 1'b0;
    logic             o_clientGrant;
    logic             o_revokeReq;
    logic             o_revokeDone;
    logic [CNT_W-1:0] o_tenureCount;
`ifdef GRANT_TENURE_STATS_EN
    logic [7:0]       o_timeoutCnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    grant_tenure_ctrl #(
        .MAX_TENURE(MAXT),
        .COOLDOWN  (COOL)
    ) dut (
        .i_ck         (i_ck),
        .i_arst       (i_arst),
        .i_grant      (i_grant),
        .i_clientReq  (i_clientReq),
        .i_clientBusy (i_clientBusy),
        .o_clientGrant(o_clientGrant),
        .o_revokeReq  (o_revokeReq),
        .o_revokeDone (o_revokeDone),
        .o_tenureCount(o_tenureCount)
`ifdef GRANT_TENURE_STATS_EN
        ,
        .o_timeoutCnt (o_timeoutCnt)
`endif
    );

    always #5 i_ck = ~i_ck;

    // Reference model: a grant episode is "forwarding" (optionally draining) or a
    // cooldown measured as age since the revoke request (-1 when none).
    bit m_fwd, m_drain;
    int m_tenure, m_age, m_tmo;

    task automatic model_reset();
        m_fwd = 0; m_drain = 0; m_tenure = 0; m_age = -1; m_tmo = 0;
    endtask

    task automatic model_step(input logic g, input logic r, input logic b);
        if (m_age >= 0) begin
            if (m_age == int'(COOL) - 1) m_age = -1;
            else m_age++;
        end else if (!m_fwd) begin
            if (g) begin m_fwd = 1; m_drain = 0; m_tenure = 0; end
        end else if (!g) begin
            m_fwd = 0;
        end else if (m_drain) begin
            if (!b) begin m_fwd = 0; m_age = 0; end
        end else if (!r || m_tenure == int'(MAXT) - 1) begin
            if (r && m_tmo < 255) m_tmo++;
            if (b) m_drain = 1;
            else begin m_fwd = 0; m_age = 0; end
        end else begin
            m_tenure++;
        end
    endtask

    function automatic logic [6:0] exp_vec();
        return {m_fwd, m_age == 0, m_age == int'(COOL) - 1, CNT_W'(m_tenure)};
    endfunction

    wire [6:0] obs_vec = {o_clientGrant, o_revokeReq, o_revokeDone, o_tenureCount};

    // Drive on the falling edge; outputs are then sampled on the next falling edge.
    task automatic drive(input logic g, input logic r, input logic b);
        i_grant = g; i_clientReq = r; i_clientBusy = b;
        model_step(g, r, b);
        @(negedge i_ck);
    endtask

    task automatic go_idle();
        repeat (8) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        i_arst = 1'b1;
        model_reset();
        repeat (2) @(negedge i_ck);
        n_total++;
        if (obs_vec !== 7'd0) $display("FAIL reset_outputs: got %b expected %b", obs_vec, 7'd0);
        else n_pass++;
`ifdef GRANT_TENURE_STATS_EN
        n_total++;
        if (o_timeoutCnt !== 8'd0) $display("FAIL reset_timeoutCnt: got %0d expected 0", o_timeoutCnt);
        else n_pass++;
`endif
        i_arst = 1'b0;
        @(negedge i_ck);
    endtask

    task automatic test_timeout();
        int hi = 0, req_at = -1, done_at = -1, bad_ten = 0;
        go_idle();
        drive(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 30; c++) begin
            if (o_clientGrant) begin
                if (o_tenureCount !== CNT_W'(hi)) bad_ten++;
                hi++;
            end
            if (o_revokeReq && req_at < 0) req_at = c;
            if (o_revokeDone && done_at < 0) done_at = c;
            drive(req_at < 0, 1'b1, 1'b0);
        end
        n_total++;
        if (hi != 16) $display("FAIL timeout_grant_cycles: got %0d expected 16", hi); else n_pass++;
        n_total++;
        if (bad_ten != 0) $display("FAIL timeout_tenure_seq: got %0d bad expected 0", bad_ten); else n_pass++;
        n_total++;
        if (req_at != 16) $display("FAIL timeout_revokeReq_cycle: got %0d expected 16", req_at); else n_pass++;
        n_total++;
        if (done_at != 19) $display("FAIL timeout_revokeDone_cycle: got %0d expected 19", done_at); else n_pass++;
    endtask

    task automatic test_release();
        bit found = 0;
        logic [7:0] tmo0 = '0;
        go_idle();
`ifdef GRANT_TENURE_STATS_EN
        tmo0 = o_timeoutCnt;
`endif
        drive(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 20 && !found; c++) begin
            if (o_clientGrant && o_tenureCount == 4'd5) found = 1;
            else drive(1'b1, 1'b1, 1'b0);
        end
        n_total++;
        if (!found) $display("FAIL release_reach_5: got %b expected 1", found); else n_pass++;
        drive(1'b1, 1'b0, 1'b0);
        n_total++;
        if ({o_clientGrant, o_revokeReq, o_tenureCount} !== {2'b01, 4'd5})
            $display("FAIL release_revoke: got %b expected %b", {o_clientGrant, o_revokeReq, o_tenureCount}, {2'b01, 4'd5});
        else n_pass++;
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        n_total++;
        if (o_tenureCount !== 4'd5) $display("FAIL release_tenure_hold: got %0d expected 5", o_tenureCount); else n_pass++;
`ifdef GRANT_TENURE_STATS_EN
        n_total++;
        if (o_timeoutCnt !== tmo0) $display("FAIL release_timeoutCnt: got %0d expected %0d", o_timeoutCnt, tmo0); else n_pass++;
`endif
        if (tmo0 != 8'd0) begin end
    endtask

    task automatic test_drain();
        bit found = 0;
        int bad = 0;
        go_idle();
        drive(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 30 && !found; c++) begin
            if (o_clientGrant && o_tenureCount == 4'd15) found = 1;
            else drive(1'b1, 1'b1, 1'b0);
        end
        n_total++;
        if (!found) $display("FAIL drain_reach_limit: got %b expected 1", found); else n_pass++;
        repeat (3) begin
            drive(1'b1, 1'b1, 1'b1);
            if (!o_clientGrant || o_revokeReq) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL drain_hold_grant: got %0d bad cycles expected 0", bad); else n_pass++;
        drive(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({o_clientGrant, o_revokeReq, o_tenureCount} !== {2'b01, 4'd15})
            $display("FAIL drain_revoke: got %b expected %b", {o_clientGrant, o_revokeReq, o_tenureCount}, {2'b01, 4'd15});
        else n_pass++;
    endtask

    task automatic test_abort();
        bit found = 0;
        int pulses = 0;
        go_idle();
        drive(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 20 && !found; c++) begin
            if (o_clientGrant && o_tenureCount == 4'd7) found = 1;
            else drive(1'b1, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0);
        n_total++;
        if ({found, o_clientGrant, o_tenureCount} !== {2'b10, 4'd7})
            $display("FAIL abort_drop: got %b expected %b", {found, o_clientGrant, o_tenureCount}, {2'b10, 4'd7});
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            if (o_revokeReq || o_revokeDone) pulses++;
            drive(1'b0, 1'b1, 1'b0);
        end
        n_total++;
        if (pulses != 0) $display("FAIL abort_no_pulses: got %0d expected 0", pulses); else n_pass++;
        drive(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({o_clientGrant, o_tenureCount} !== {1'b1, 4'd0})
            $display("FAIL abort_regrant: got %b expected %b", {o_clientGrant, o_tenureCount}, {1'b1, 4'd0});
        else n_pass++;
    endtask

    task automatic test_reset_in_cooldown();
        bit found = 0;
        int dones = 0;
        go_idle();
        for (int c = 0; c < 40 && !found; c++) begin
            drive(1'b1, 1'b1, 1'b0);
            if (o_revokeReq) found = 1;
        end
        drive(1'b0, 1'b1, 1'b0);
        #2 i_arst = 1'b1;
        #1;
        n_total++;
        if ({found, obs_vec} !== {1'b1, 7'd0}) $display("FAIL rstcool_outputs: got %b expected %b", {found, obs_vec}, {1'b1, 7'd0});
        else n_pass++;
        model_reset();
        i_grant = 1'b0;
        repeat (3) begin
            @(negedge i_ck);
            if (o_revokeDone) dones++;
        end
        i_arst = 1'b0;
        repeat (3) begin
            drive(1'b0, 1'b0, 1'b0);
            if (o_revokeDone) dones++;
        end
        n_total++;
        if (dones != 0) $display("FAIL rstcool_no_done: got %0d expected 0", dones); else n_pass++;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({o_clientGrant, o_tenureCount} !== {1'b1, 4'd1})
            $display("FAIL rstcool_restart: got %b expected %b", {o_clientGrant, o_tenureCount}, {1'b1, 4'd1});
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0);
            n_total++;
            if (obs_vec !== exp_vec()) begin
                if (errs < 10) $display("FAIL random_cycle%0d: got %b expected %b", c, obs_vec, exp_vec());
                errs++;
            end else n_pass++;
`ifdef GRANT_TENURE_STATS_EN
            n_total++;
            if (o_timeoutCnt !== 8'(m_tmo)) begin
                if (errs < 10) $display("FAIL random_tmo%0d: got %0d expected %0d", c, o_timeoutCnt, m_tmo);
                errs++;
            end else n_pass++;
`endif
        end
    endtask

`ifdef GRANT_TENURE_STATS_EN
    task automatic test_stats_saturation();
        int stuck = 0;
        go_idle();
        for (int k = 0; k < 300; k++) begin
            bit done = 0;
            for (int c = 0; c < 40 && !done; c++) begin
                drive(1'b1, 1'b1, 1'b0);
                if (o_revokeDone) done = 1;
            end
            if (!done) stuck++;
            drive(1'b0, 1'b0, 1'b0);
        end
        n_total++;
        if (stuck != 0) $display("FAIL stats_grants_complete: got %0d stuck expected 0", stuck); else n_pass++;
        n_total++;
        if (o_timeoutCnt !== 8'd255) $display("FAIL stats_saturate: got %0d expected 255", o_timeoutCnt); else n_pass++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_timeout();
        test_release();
        test_drain();
        test_abort();
        test_reset_in_cooldown();
        test_random();
`ifdef GRANT_TENURE_STATS_EN
        test_stats_saturation();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/grant_tenure_ctrl.md
Name: grant_tenure_ctrl

Overview:
Downstream companion of the request/grant FSM. It consumes that FSM's grant level (its o_state3 output) and forwards the grant to the client. It bounds grant tenure with a cycle counter and defers revocation while the client is mid-transaction. It generates the two single-cycle pulses that drive the FSM's GRANT->REVOKE and REVOKE->IDLE transitions (i_stateTransition3 and i_stateTransition4).

Parameters:
MAX_TENURE, 16, maximum cycles in S_ACTIVE before a forced revoke; must be >= 2
COOLDOWN, 4, cycles spent in S_COOLDOWN, from the revoke request up to and including revoke-done; must be >= 2
(localparam CNT_W = $clog2(MAX_TENURE); width of the tenure counter)

Ports:
i_ck  input  1  clock, rising edge
i_arst  input  1  reset, asynchronous, active-high
i_grant  input  1  grant level from the FSM (high while the FSM is in GRANT)
i_clientReq  input  1  client still wants the resource (level)
i_clientBusy  input  1  client is mid-transaction; revoke must wait
o_clientGrant  output  1  grant forwarded to the client
o_revokeReq  output  1  one-cycle pulse; drives the FSM's i_stateTransition3
o_revokeDone  output  1  one-cycle pulse; drives the FSM's i_stateTransition4
o_tenureCount  output  CNT_W  cycles spent in S_ACTIVE during the current or last grant

Behaviour:
- Reset (async, any state): state = S_IDLE, tenure = 0, cooldown counter = 0. All outputs are 0.
- States: S_IDLE, S_ACTIVE, S_DRAIN, S_COOLDOWN. All outputs are Moore decodes of registered state and counters.
- S_IDLE:
  - o_clientGrant = 0.
  - If i_grant = 1, go to S_ACTIVE and clear tenure to 0.
- S_ACTIVE:
  - o_clientGrant = 1. Tenure increments each cycle spent in S_ACTIVE; the first cycle shows 0.
  - trigger = (i_clientReq = 0) OR (tenure = MAX_TENURE-1).
  - On trigger with i_clientBusy = 0: go to S_COOLDOWN and load the cooldown counter with COOLDOWN-1.
  - On trigger with i_clientBusy = 1: go to S_DRAIN.
  - Tenure holds its value once S_ACTIVE is left.
- S_DRAIN:
  - o_clientGrant = 1.
  - When i_clientBusy = 0, go to S_COOLDOWN and load COOLDOWN-1.
  - S_DRAIN has no upper bound on duration.
- S_COOLDOWN:
  - o_clientGrant = 0.
  - o_revokeReq = 1 only in the first S_COOLDOWN cycle (cooldown counter = COOLDOWN-1).
  - The cooldown counter decrements every cycle.
  - o_revokeDone = 1 when the cooldown counter = 0; the next state is S_IDLE.
  - Result: o_revokeDone follows o_revokeReq by exactly COOLDOWN-1 cycles, and the two pulses never coincide.
- Grant loss: i_grant = 0 while in S_ACTIVE or S_DRAIN is an upstream abort.
  - Go to S_IDLE on the next edge; o_clientGrant drops that cycle.
  - No o_revokeReq or o_revokeDone pulse is generated.
  - Abort takes priority over the trigger in the same cycle.
- i_grant is ignored in S_COOLDOWN; its fall there is the expected response to o_revokeReq.
- Trigger cause: if release (i_clientReq = 0) and tenure limit occur in the same cycle, the cause is release.
- Tenure never wraps; the maximum observable value is MAX_TENURE-1.

Optional Feature:
GRANT_TENURE_STATS_EN
- Defined: adds output o_timeoutCnt [7:0].
  - Reset value 0.
  - Increments on entering S_COOLDOWN/S_DRAIN when the trigger cause is the tenure limit (not release).
  - Saturates at 255.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Timeout path (MAX_TENURE = 16, COOLDOWN = 4): i_grant rises, i_clientReq = 1, i_clientBusy = 0.
  - S_ACTIVE lasts 16 cycles; o_tenureCount runs 0..15.
  - o_revokeReq pulses the next cycle; o_revokeDone pulses 3 cycles later; S_IDLE follows.
  - o_clientGrant is high for exactly 16 cycles.
- Release path: client drops i_clientReq when o_tenureCount = 5.
  - o_revokeReq pulses next cycle; o_tenureCount holds 5.
  - o_timeoutCnt does not change (stats build).
- Drain: tenure limit reached with i_clientBusy = 1 for 3 more cycles.
  - o_clientGrant stays 1 through S_DRAIN.
  - o_revokeReq fires the cycle after i_clientBusy falls.
- Abort: i_grant falls when o_tenureCount = 7.
  - o_clientGrant = 0 the next cycle; state is S_IDLE.
  - o_revokeReq and o_revokeDone are never asserted.
- Reset in S_COOLDOWN: assert i_arst one cycle after o_revokeReq.
  - All outputs are 0 immediately and no o_revokeDone occurs.
  - After release, a new i_grant restarts from tenure 0.
- Stats saturation (GRANT_TENURE_STATS_EN): 300 consecutive timeout grants -> o_timeoutCnt = 255.
